// File: rtl/div_hilo_ctrl_if.sv
// EX-side operation/HI-LO bus plus the divider start/result handshake of div_hilo_ctrl.
// master = EX stage and divider, slave = the controller.
interface div_hilo_ctrl_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_result;
    logic        div_ready;
    logic        div_err;

    modport master (
        output op_valid, op_code, op_a, op_b, flush, div_result, div_ready,
        input  stall, hi, lo, div_start, div_signed, div_a, div_b, div_err
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush, div_result, div_ready,
        output stall, hi, lo, div_start, div_signed, div_a, div_b, div_err
    );
endinterface

// File: rtl/div_hilo_ctrl.sv
// HI/LO issue/writeback controller for the iterative divider: divides retire ~9 cycles after accept, MTHI/MTLO in 1; EX stalled while a divide is in flight.
// Optional DIV_ZERO_BYPASS_EN: x/0 retires in IDLE (hi=x, lo=all-ones) without starting the divider.
module div_hilo_ctrl #(
    parameter int DIV_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    div_hilo_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int            TW       = $clog2(DIV_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   div_a_q, div_b_q;
    logic          signed_q;
    logic          err_q;

    logic accept;
    logic is_div;
    logic zero_bypass;
    logic div_accept;
    logic mt_accept;
    logic in_flight;
    logic timeout;
    logic retire;

    always_comb begin
        accept    = bus.op_valid & (state_q == IDLE) & ~bus.flush;
        is_div    = ~bus.op_code[1];
`ifdef DIV_ZERO_BYPASS_EN
        zero_bypass = accept & is_div & (bus.op_b == 32'd0);
`else
        zero_bypass = 1'b0;
`endif
        div_accept = accept & is_div & ~zero_bypass;
        mt_accept  = accept & ~is_div;
        in_flight  = (state_q == BUSY) | (state_q == DRAIN);
        timeout    = in_flight & ~bus.div_ready & (tmo_q == TMO_LAST);
        // A completed divide retires even if flush arrives in the same cycle.
        retire     = (state_q == BUSY) & bus.div_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (div_accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.div_ready || timeout) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else if (bus.flush) begin
                    // Start must stay high until the divider finishes, so drain it.
                    state_d = DRAIN;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DRAIN: begin
                if (bus.div_ready || timeout) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (retire) begin
            hi_q <= bus.div_result[63:32];
            lo_q <= bus.div_result[31:0];
        end else if (zero_bypass) begin
            hi_q <= bus.op_a;
            lo_q <= '1;
        end else if (mt_accept) begin
            if (bus.op_code[0]) begin
                lo_q <= bus.op_a;
            end else begin
                hi_q <= bus.op_a;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_a_q  <= '0;
            div_b_q  <= '0;
            signed_q <= 1'b0;
        end else if (div_accept) begin
            div_a_q  <= bus.op_a;
            div_b_q  <= bus.op_b;
            signed_q <= bus.op_code[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    // Start drops combinationally with ready so the divider does not relaunch.
    assign bus.div_start  = in_flight & ~bus.div_ready;
    assign bus.stall      = bus.op_valid & ((state_q != IDLE) | div_accept);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.div_a      = div_a_q;
    assign bus.div_b      = div_b_q;
    assign bus.div_signed = signed_q;
    assign bus.div_err    = err_q;

endmodule
